uart_rx: RTL and testbench

Receives asynchronous serial frames (1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit) on a raw input pin. The pin is first passed through an internal `synchronizer` instance. The block then oversamples the clean line, checks the stop bit, and presents each received word on a single-entry valid/ready output buffer. It sits between the board-level UART RX pin and the UART/MMIO front end that feeds the core.

---
 rtl/uart_pkg.sv | 18 +
 rtl/synchronizer.sv | 31 +++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame-format constants for the UART receive path.
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Line levels that delimit a frame.
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage : uart_pkg

// File: rtl/synchronizer.sv
// Multi-flop synchronizer that brings an asynchronous input into the clk domain.
module synchronizer #(
    parameter int                    DATA_WIDTH = 1,
    parameter int                    SYNC_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] stage [SYNC_DEPTH];

    // Shift the raw input through the flop chain; reset reloads the idle value.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= i_data;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign o_data = stage[SYNC_DEPTH-1];

endmodule : synchronizer

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the pin, oversamples each bit at mid-period,
// checks the stop bit and holds the received word in a one-entry valid/ready buffer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_rx_async,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_frame_err,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    logic                  rx;
    rx_state_t             state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  word_done;

    synchronizer #(
        .DATA_WIDTH (1),
        .SYNC_DEPTH (SYNC_DEPTH),
        .RESET_VAL  (IDLE_LEVEL)
    ) u_sync (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_data (i_rx_async),
        .o_data (rx)
    );

    // A good stop bit completes the word in the same cycle it is sampled, so
    // the output buffer sees it without an extra pipeline stage.
    assign word_done = (state == STOP) && (bit_cnt == CNT_LAST) && (rx == STOP_LEVEL);

    // Frame state machine: bit timing, data capture, stop check and busy decode.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            idx         <= '0;
            // NOTE: the shift register is reset too, so an aborted frame leaves no stale bits behind.
            shift       <= '0;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment in this block overrides these defaults.
            o_frame_err <= 1'b0;
            bit_cnt     <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (rx == START_LEVEL) begin
                        state  <= START;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt == CNT_HALF) begin
                        bit_cnt <= '0;
                        if (rx == START_LEVEL) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            // Line went back high before mid-bit: treat as a glitch.
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        shift[idx] <= rx;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_cnt == CNT_LAST) begin
                        if (rx == STOP_LEVEL) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state       <= WAIT_IDLE;
                            o_frame_err <= 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // Stay out of IDLE until the line recovers, so a break is not seen as a start bit.
                    if (rx == STOP_LEVEL) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry output buffer: load on completion, drain on handshake, flag drops.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (word_done) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shift;
                    o_valid <= 1'b1;
                end else begin
                    // Buffer is full and not draining: the new word is lost, the old one kept.
                    o_overrun <= 1'b1;
                end
            end
        end
    end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events with their
// arrival cycle; a negedge monitor pops and compares whenever the DUT reports one.
module tb_uart_rx;

    localparam int DW   = 8;
    localparam int CPB  = 16;
    localparam int SD   = 2;
    // Raw falling edge of the start bit to the first cycle the outputs show the result.
    localparam int LAT  = SD + CPB / 2 + (DW + 1) * CPB + 1;

    typedef enum int { EV_WORD, EV_FERR, EV_OVR } ev_t;
    typedef struct {
        ev_t          kind;
        logic [DW-1:0] data;
        int           cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          rx_line;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];
    logic prev_valid = 1'b0;
    logic prev_xfer  = 1'b0;

    uart_rx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .SYNC_DEPTH   (SD)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_rx_async  (rx_line),
        .i_ready     (ready),
        .o_valid     (valid),
        .o_data      (data),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge; all stimulus changes here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the mid-cycle sample point of cycle c (c must not be in the past).
    task automatic wait_to(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive one full frame from an aligned point. Optionally queue the expected
    // event, and optionally raise ready for exactly the stop-sample cycle.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit,
                              input logic has_exp, input ev_t kind,
                              input logic [DW-1:0] exp_data, input logic ready_pulse);
        int   n0;
        exp_t e;
        n0 = cyc;
        if (has_exp) begin
            e.kind = kind;
            e.data = exp_data;
            e.cyc  = n0 + LAT;
            exp_q.push_back(e);
        end
        rx_line = 1'b0;
        repeat (CPB) step();
        for (int k = 0; k < DW; k++) begin
            rx_line = d[k];
            repeat (CPB) step();
        end
        rx_line = stop_bit;
        for (int c = 0; c < CPB; c++) begin
            if (ready_pulse) ready = (cyc == n0 + LAT - 1);
            step();
        end
        if (ready_pulse) ready = 1'b0;
    endtask

    task automatic handle(input ev_t k);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got event %0d with data 0x%0h at cycle %0d, expected none",
                     k, data, cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", k, e.kind);
            check("ev_cycle", cyc, e.cyc);
            if (k == EV_FERR) check("ferr_no_valid", valid, 0);
            else              check("ev_data", data, e.data);
        end
    endtask

    // Monitor: a newly presented word, a frame error or an overrun is an event.
    always @(negedge clk) begin
        if (n_rst) begin
            if (valid && (!prev_valid || prev_xfer)) handle(EV_WORD);
            if (frame_err) handle(EV_FERR);
            if (overrun)   handle(EV_OVR);
        end
        prev_valid = valid;
        prev_xfer  = valid && ready;
    end

    initial begin
        int n0;
        int m;
        n_rst   = 1'b0;
        rx_line = 1'b1;
        ready   = 1'b0;
        repeat (3) step();

        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        step();
        n_rst = 1'b1;
        ready = 1'b1;
        repeat (4) step();

        // Plain frame, consumer always ready.
        send_frame(8'hA5, 1'b1, 1'b1, EV_WORD, 8'hA5, 1'b0);
        repeat (4) step();

        // Short low glitch: START aborts at the mid-bit sample.
        n0 = cyc;
        rx_line = 1'b0;
        repeat (4) step();
        rx_line = 1'b1;
        wait_to(n0 + SD + CPB / 2);
        check("glitch_busy_before_sample", busy, 1);
        wait_to(n0 + SD + CPB / 2 + 1);
        check("glitch_busy_after_sample", busy, 0);
        step();
        send_frame(8'h5A, 1'b1, 1'b1, EV_WORD, 8'h5A, 1'b0);
        step();

        // Stop bit low followed by a held-low line.
        send_frame(8'h3C, 1'b0, 1'b1, EV_FERR, 8'h00, 1'b0);
        @(negedge clk);
        check("break_busy", busy, 1);
        repeat (40) step();
        @(negedge clk);
        check("break_busy_held", busy, 1);
        step();
        m = cyc;
        rx_line = 1'b1;
        wait_to(m + SD);
        check("break_busy_until_idle", busy, 1);
        wait_to(m + SD + 1);
        check("break_busy_released", busy, 0);
        step();
        send_frame(8'h81, 1'b1, 1'b1, EV_WORD, 8'h81, 1'b0);
        step();

        // Back-to-back frames with no consumer: second word overruns.
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1, EV_WORD, 8'h11, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, EV_OVR, 8'h11, 1'b0);
        @(negedge clk);
        check("ovr_valid_held", valid, 1);
        check("ovr_data_held", data, 8'h11);
        step();
        ready = 1'b1;
        @(negedge clk);
        check("drain_valid_during", valid, 1);
        step();
        ready = 1'b0;
        @(negedge clk);
        check("drain_valid_after", valid, 0);
        step();

        // Consumer drains exactly at the completion of the next word: no overrun.
        send_frame(8'h11, 1'b1, 1'b1, EV_WORD, 8'h11, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, EV_WORD, 8'h22, 1'b1);
        @(negedge clk);
        check("swap_valid", valid, 1);
        check("swap_data", data, 8'h22);
        step();
        ready = 1'b1;
        step();

        // Reset in the middle of data bit 3 of an all-ones frame.
        fork
            send_frame(8'hFF, 1'b1, 1'b0, EV_WORD, 8'h00, 1'b0);
            begin
                repeat (CPB + 3 * CPB + CPB / 2 - 1) step();
                @(negedge clk);
                check("mid_frame_busy", busy, 1);
                step();
                n_rst = 1'b0;
                step();
                @(negedge clk);
                check("mid_rst_valid", valid, 0);
                check("mid_rst_data", data, 0);
                check("mid_rst_frame_err", frame_err, 0);
                check("mid_rst_overrun", overrun, 0);
                check("mid_rst_busy", busy, 0);
                step();
                n_rst = 1'b1;
            end
        join
        step();
        send_frame(8'h0F, 1'b1, 1'b1, EV_WORD, 8'h0F, 1'b0);
        repeat (4) step();

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_rx
